// File: rtl/voice_allocator_if.sv
// Event handshake and voice_controller write-port bundle for voice_allocator.
// The master side issues note events and observes the write port; the
// slave side is the allocator itself.
interface voice_allocator_if #(
  parameter int IDX_W = 8
);
  // Event handshake
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_note_on;
  logic [6:0]       evt_note;
  logic [6:0]       evt_velocity;
  logic [31:0]      evt_tuning_code;
  // voice_controller write port
  logic             SPI_note_status;
  logic [IDX_W-1:0] SPI_voice_index;
  logic [31:0]      SPI_tuning_code;
  logic [6:0]       SPI_velocity;
  logic             SPI_flag;
  // Occupancy
  logic [IDX_W:0]   active_count;

  modport master (
    output evt_valid, evt_note_on, evt_note, evt_velocity, evt_tuning_code,
    input  evt_ready, SPI_note_status, SPI_voice_index, SPI_tuning_code,
    input  SPI_velocity, SPI_flag, active_count
  );

  modport slave (
    input  evt_valid, evt_note_on, evt_note, evt_velocity, evt_tuning_code,
    output evt_ready, SPI_note_status, SPI_voice_index, SPI_tuning_code,
    output SPI_velocity, SPI_flag, active_count
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler in front of voice_controller.
// Each accepted event walks the whole voice table one voice per cycle,
// collecting the first matching held voice, the first free voice and the
// oldest held voice, then issues a single write strobe and updates the table.
// Note-on priority: retrigger a match, else take a free voice, else steal the
// oldest. A note-on with velocity 0 is handled as a note-off.
module voice_allocator #(
  parameter int NUM_VOICES = 256,
  parameter int IDX_W      = 8,
  parameter int STAMP_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  voice_allocator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  // FSM and latched event
  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_evt_on;
  logic [6:0]         r_evt_note;
  logic [6:0]         r_evt_vel;
  logic [31:0]        r_evt_tc;

  // Scan results
  logic               r_match_vld;
  logic [IDX_W-1:0]   r_match_idx;
  logic               r_free_vld;
  logic [IDX_W-1:0]   r_free_idx;
  logic               r_old_vld;
  logic [IDX_W-1:0]   r_old_idx;
  logic [STAMP_W-1:0] r_old_age;

  // Voice table
  logic [NUM_VOICES-1:0] r_held;
  logic [6:0]            r_note  [NUM_VOICES];
  logic [STAMP_W-1:0]    r_stamp [NUM_VOICES];
  logic [STAMP_W-1:0]    r_stamp_ctr;
  logic [IDX_W:0]        r_active_count;

  // Registered outputs
  logic               r_ready;
  logic               r_flag;
  logic               r_status;
  logic [IDX_W-1:0]   r_vidx;
  logic [31:0]        r_tc;
  logic [6:0]         r_vel;

  // Combinational view of the voice under scan and the note-on target
  logic               w_cur_held;
  logic               w_cur_match;
  logic [STAMP_W-1:0] w_cur_age;
  logic [IDX_W-1:0]   w_on_target;
  logic               w_eff_on;

  // Decode the current voice, the effective event kind and the note-on target
  always_comb begin
    w_cur_held  = r_held[r_idx];
    w_cur_match = 1'b0;
    w_cur_age   = r_stamp_ctr - r_stamp[r_idx];
    if (w_cur_held && (r_note[r_idx] == r_evt_note)) begin
      w_cur_match = 1'b1;
    end else begin
      w_cur_match = 1'b0;
    end
    if (bus.evt_note_on && (bus.evt_velocity != 7'd0)) begin
      w_eff_on = 1'b1;
    end else begin
      w_eff_on = 1'b0;
    end
    if (r_match_vld) begin
      w_on_target = r_match_idx;
    end else if (r_free_vld) begin
      w_on_target = r_free_idx;
    end else begin
      w_on_target = r_old_idx;
    end
  end

  // Allocator FSM: accept, scan the table, issue one write and update held/count
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_idx          <= {IDX_W{1'b0}};
      r_evt_on       <= 1'b0;
      r_evt_note     <= 7'd0;
      r_evt_vel      <= 7'd0;
      r_evt_tc       <= 32'd0;
      r_match_vld    <= 1'b0;
      r_match_idx    <= {IDX_W{1'b0}};
      r_free_vld     <= 1'b0;
      r_free_idx     <= {IDX_W{1'b0}};
      r_old_vld      <= 1'b0;
      r_old_idx      <= {IDX_W{1'b0}};
      r_old_age      <= {STAMP_W{1'b0}};
      r_held         <= {NUM_VOICES{1'b0}};
      r_stamp_ctr    <= {STAMP_W{1'b0}};
      r_active_count <= {(IDX_W+1){1'b0}};
      r_ready        <= 1'b0;
      r_flag         <= 1'b0;
      r_status       <= 1'b0;
      r_vidx         <= {IDX_W{1'b0}};
      r_tc           <= 32'd0;
      r_vel          <= 7'd0;
    end else begin
      r_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.evt_valid && r_ready) begin
            r_ready     <= 1'b0;
            r_evt_on    <= w_eff_on;
            r_evt_note  <= bus.evt_note;
            r_evt_vel   <= bus.evt_velocity;
            r_evt_tc    <= bus.evt_tuning_code;
            r_match_vld <= 1'b0;
            r_free_vld  <= 1'b0;
            r_old_vld   <= 1'b0;
            r_old_age   <= {STAMP_W{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_state     <= S_SCAN;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_cur_match && !r_match_vld) begin
            r_match_vld <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (!w_cur_held && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
          end
          // Strictly-greater keeps the lowest index on equal ages
          if (w_cur_held && (!r_old_vld || (w_cur_age > r_old_age))) begin
            r_old_vld <= 1'b1;
            r_old_idx <= r_idx;
            r_old_age <= w_cur_age;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= S_ISSUE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_ISSUE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          if (r_evt_on) begin
            r_flag              <= 1'b1;
            r_status            <= 1'b1;
            r_vidx              <= w_on_target;
            r_tc                <= r_evt_tc;
            r_vel               <= r_evt_vel;
            r_held[w_on_target] <= 1'b1;
            r_stamp_ctr         <= r_stamp_ctr + STAMP_W'(1);
            // Only a previously free voice raises the count; retrigger and steal keep it
            if (!r_match_vld && r_free_vld) begin
              r_active_count <= r_active_count + {{IDX_W{1'b0}}, 1'b1};
            end
          end else if (r_match_vld) begin
            r_flag              <= 1'b1;
            r_status            <= 1'b0;
            r_vidx              <= r_match_idx;
            r_tc                <= r_evt_tc;
            r_vel               <= 7'd0;
            r_held[r_match_idx] <= 1'b0;
            r_active_count      <= r_active_count - {{IDX_W{1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Note and age stamp of the note-on target; contents only matter while held
  always_ff @(posedge i_clk) begin
    if ((r_state == S_ISSUE) && r_evt_on) begin
      r_note[w_on_target]  <= r_evt_note;
      r_stamp[w_on_target] <= r_stamp_ctr;
    end
  end

  assign bus.evt_ready       = r_ready;
  assign bus.SPI_flag        = r_flag;
  assign bus.SPI_note_status = r_status;
  assign bus.SPI_voice_index = r_vidx;
  assign bus.SPI_tuning_code = r_tc;
  assign bus.SPI_velocity    = r_vel;
  assign bus.active_count    = r_active_count;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator with 4 voices and 4-bit stamps. Stimulus pushes
// expected writes into a scoreboard queue; a monitor pops and compares on
// every write strobe. Directed scenarios cover reset, retrigger, steal,
// note-off, velocity-0 and mid-scan reset; a random phase follows.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int IW = 2;
  localparam int SW = 4;

  typedef struct {
    bit        status;
    int        idx;
    bit [31:0] tc;
    int        vel;
    int        count;
    int        cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  exp_t sb[$];

  // Reference voice table
  bit        m_held[NV];
  int        m_note[NV];
  int        m_stamp[NV];
  int        m_ctr;
  int        m_count;

  voice_allocator_if #(.IDX_W(IW)) bus();

  voice_allocator #(.NUM_VOICES(NV), .IDX_W(IW), .STAMP_W(SW)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_held[i] = 1'b0;
      m_note[i] = 0;
      m_stamp[i] = 0;
    end
    m_ctr = 0;
    m_count = 0;
  endtask

  // Apply one accepted event to the reference table and queue the expected write
  task automatic model_event(bit on, int note, int vel, bit [31:0] tc, int hs_cyc);
    int match = -1;
    int free = -1;
    int old = -1;
    int old_age = -1;
    int age;
    int tgt;
    exp_t e;
    for (int i = 0; i < NV; i++) begin
      if (m_held[i] && m_note[i] == note && match < 0) match = i;
      if (!m_held[i] && free < 0) free = i;
      if (m_held[i]) begin
        age = (m_ctr - m_stamp[i] + 16 * (1 << SW)) % (1 << SW);
        if (age > old_age) begin
          old_age = age;
          old = i;
        end
      end
    end
    if (on && vel != 0) begin
      tgt = (match >= 0) ? match : ((free >= 0) ? free : old);
      if (match < 0 && free >= 0) m_count++;
      m_held[tgt] = 1'b1;
      m_note[tgt] = note;
      m_stamp[tgt] = m_ctr;
      m_ctr = (m_ctr + 1) % (1 << SW);
      e.status = 1'b1; e.idx = tgt; e.tc = tc; e.vel = vel;
      e.count = m_count; e.cyc = hs_cyc + NV + 1;
      sb.push_back(e);
    end else if (match >= 0) begin
      m_held[match] = 1'b0;
      m_count--;
      e.status = 1'b0; e.idx = match; e.tc = tc; e.vel = 0;
      e.count = m_count; e.cyc = hs_cyc + NV + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.evt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.evt_ready) check("evt_ready_timeout", bus.evt_ready, 1'b1);
  endtask

  task automatic drive(bit on, int note, int vel, bit [31:0] tc);
    bus.evt_valid = 1'b1;
    bus.evt_note_on = on;
    bus.evt_note = 7'(note);
    bus.evt_velocity = 7'(vel);
    bus.evt_tuning_code = tc;
    @(posedge clk);
    #1;
    bus.evt_valid = 1'b0;
    bus.evt_note_on = 1'($urandom);
    bus.evt_note = 7'($urandom);
    bus.evt_velocity = 7'($urandom);
    bus.evt_tuning_code = $urandom;
  endtask

  task automatic send(bit on, int note, int vel, bit [31:0] tc);
    wait_ready();
    if (bus.evt_ready) begin
      drive(on, note, vel, tc);
      model_event(on, note, vel, tc, cyc);
    end
  endtask

  task automatic check_out(string tag, bit status, int idx, int vel, int count);
    wait_ready();
    check({tag, "_status"}, bus.SPI_note_status, status);
    check({tag, "_index"}, bus.SPI_voice_index, idx);
    check({tag, "_velocity"}, bus.SPI_velocity, vel);
    check({tag, "_count"}, bus.active_count, count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.evt_ready, 1'b0);
    check("rst_flag", bus.SPI_flag, 1'b0);
    check("rst_count", bus.active_count, 0);
    check("rst_outputs", {bus.SPI_note_status, bus.SPI_voice_index, bus.SPI_tuning_code, bus.SPI_velocity}, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.evt_valid = 1'b0;
    bus.evt_note_on = 1'b0;
    bus.evt_note = 7'd0;
    bus.evt_velocity = 7'd0;
    bus.evt_tuning_code = 32'd0;
    model_reset();
    fork
      // Monitor: every write strobe must match the oldest queued expectation
      begin
        bit prev_flag = 1'b0;
        exp_t e;
        while (!done) begin
          @(negedge clk);
          if (rst_n && bus.SPI_flag) begin
            check("flag_back_to_back", prev_flag, 1'b0);
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_flag: got flag at index %0d expected none", bus.SPI_voice_index);
            end else begin
              e = sb.pop_front();
              check("sb_status", bus.SPI_note_status, e.status);
              check("sb_index", bus.SPI_voice_index, e.idx);
              check("sb_tuning", bus.SPI_tuning_code, e.tc);
              check("sb_velocity", bus.SPI_velocity, e.vel);
              check("sb_count", bus.active_count, e.count);
              check("sb_latency", cyc, e.cyc);
            end
          end
          prev_flag = bus.SPI_flag;
        end
      end
      // Stimulus
      begin
        do_reset();
        // 1: first note-on lands on voice 0
        send(1'b1, 60, 100, 32'h1000);
        check_out("t1", 1'b1, 0, 100, 1);
        check("t1_tuning", bus.SPI_tuning_code, 32'h1000);

        // 2: fill all voices, then steal the oldest
        do_reset();
        send(1'b1, 60, 100, 32'h600);
        send(1'b1, 62, 100, 32'h620);
        send(1'b1, 64, 100, 32'h640);
        send(1'b1, 65, 100, 32'h650);
        send(1'b1, 67, 90, 32'h670);
        check_out("t2", 1'b1, 0, 90, 4);

        // 3: retrigger keeps the voice and count
        do_reset();
        send(1'b1, 60, 100, 32'h600);
        send(1'b1, 60, 50, 32'h601);
        check_out("t3", 1'b1, 0, 50, 1);

        // 4: note-off releases; a second note-off is dropped
        do_reset();
        send(1'b1, 60, 100, 32'h600);
        send(1'b0, 60, 33, 32'h602);
        check_out("t4", 1'b0, 0, 0, 0);
        send(1'b0, 60, 33, 32'h603);
        repeat (NV + 4) @(negedge clk);
        check("t4_drop_count", bus.active_count, 0);

        // 5: velocity 0 behaves as note-off
        do_reset();
        send(1'b1, 60, 0, 32'h600);
        repeat (NV + 4) @(negedge clk);
        check("t5_drop_count", bus.active_count, 0);
        send(1'b1, 61, 80, 32'h610);
        send(1'b1, 61, 0, 32'h611);
        check_out("t5", 1'b0, 0, 0, 0);

        // 6: reset mid-scan discards the event and clears the table
        do_reset();
        send(1'b1, 50, 100, 32'h500);
        send(1'b1, 51, 100, 32'h510);
        wait_ready();
        drive(1'b1, 52, 100, 32'h520);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (NV + 4) @(negedge clk);
        send(1'b1, 70, 77, 32'h700);
        check_out("t6", 1'b1, 0, 77, 1);

        // Stamp wrap: steal order stays round-robin across the wrap
        do_reset();
        for (int i = 0; i < 20; i++) begin
          send(1'b1, 40 + i, 10 + i, 32'(i));
          wait_ready();
          check("wrap_index", bus.SPI_voice_index, i % NV);
        end
        check("wrap_count", bus.active_count, NV);

        // Random phase
        do_reset();
        for (int i = 0; i < 300; i++) begin
          bit on;
          int vel;
          on = ($urandom_range(0, 9) < 7);
          vel = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
          send(on, 60 + int'($urandom_range(0, 5)), vel, $urandom);
        end
        wait_ready();
        repeat (2) @(negedge clk);
        check("final_count", bus.active_count, m_count);
        check("scoreboard_empty", sb.size(), 0);
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
